// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_unit
// Purpose  : Digit-serial adder/subtractor. Processes DIGIT bits per clock,
//            LSB first, behind a start/busy/done handshake. Result, carry-out
//            and signed-overflow flags are registered and only change when
//            an operation completes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             d,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // Number of digit cycles and a counter wide enough to index them
    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    // Controller states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;        // operand A, shifted right one digit per clock
    logic [WIDTH-1:0]   r_b;        // operand B (pre-inverted for subtract)
    logic               r_carry;    // carry between digits
    logic [c_CNT_W-1:0] r_cnt;      // digit index
    logic [WIDTH-1:0]   r_acc;      // partial sum, filled from the MSB side
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_cin_msb;
    logic               w_accept;
    logic               w_last;

    // Digit adder, partial-sum shift and completion decode
    always_comb begin
        w_dsum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
        w_acc_next = WIDTH'({w_dsum[DIGIT-1:0], r_acc} >> DIGIT);
        // Carry into the top bit of this digit, recovered from the sum bit;
        // on the final digit this is the carry into the operand MSB.
        w_cin_msb  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
        w_accept   = start && (r_state != c_RUN);
        w_last     = (r_cnt == c_LAST);
    end

    // Sequencer and datapath registers; outputs update only at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{d}};
                        r_carry <= d;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dsum[DIGIT];
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s     <= w_acc_next;
                        r_cout  <= w_dsum[DIGIT];
                        r_ovf   <= w_cin_msb ^ w_dsum[DIGIT];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational adder/subtractor.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first, through a start/busy/done handshake.
- Registered result with carry-out and signed-overflow flags; sits beside datapath blocks where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only while busy=0
- A  input  WIDTH  operand A, latched when start is accepted
- B  input  WIDTH  operand B, latched when start is accepted
- d  input  1  mode, latched with operands: 0 = A+B, 1 = A-B
- S  output  WIDTH  registered result
- Cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - S=0, Cout=0, ovf=0, busy=0, done=0.
  - Internal carry, digit counter and shift registers cleared; state=IDLE.
- N = WIDTH/DIGIT digit cycles.
- States:
  - IDLE: waiting for start.
  - RUN: processing one digit per clock.
  - DONE: one cycle, done=1; next state IDLE.
- Accept: in IDLE or DONE, start=1 at edge E0:
  - Latch A, B XOR {WIDTH{d}}, carry=d, counter=0; state=RUN.
  - busy=1 from after E0.
- RUN, edges E1..EN:
  - Add the low DIGIT bits of the operand shift registers plus carry.
  - Shift the sum into the result register from the MSB side.
  - Update carry and increment the counter.
  - At EN, also capture the carry into the MSB (for ovf).
- Completion, at edge EN:
  - S, Cout and ovf are updated together.
  - ovf = carry into MSB XOR carry out of MSB.
  - busy=0 and done=1 for exactly the cycle after EN; done=0 after E(N+1) unless another op completes.
- Latency: done asserted N cycles after the start-accepting edge.
- Outputs S, Cout and ovf hold their values until the next completion; they never show partial sums.
- start while busy=1: ignored, with no effect on the operation in flight.
- start during the DONE cycle: accepted (back-to-back); next result completes N cycles later.
- A, B and d changes after acceptance: no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH; subtraction is A + ~B + 1.
- Reset asserted mid-operation: abort immediately, all outputs 0; the first operation after reset release behaves normally.
- DIGIT=WIDTH: N=1 and behaviour stays cycle-consistent (done one cycle after accept).

Test Plan (WIDTH=8, DIGIT=2, N=4):
- A=0x80, B=0x03, d=0, start pulse -> busy for 4 cycles; then S=0x83, Cout=0, ovf=0, done high exactly 1 cycle.
- A=0x80, B=0x03, d=1 -> S=0x7D, Cout=1, ovf=1.
- A=0xFF, B=0x01, d=0 -> S=0x00, Cout=1, ovf=0. Then A=0x7F, B=0x01, d=0 -> S=0x80, Cout=0, ovf=1.
- A=0x03, B=0x08, d=1 -> S=0xFB, Cout=0, ovf=0. Change A/B and pulse start during busy -> result unchanged, no extra done.
- Back-to-back: start held high across the done cycle with A=0x10, B=0x20, d=0 -> second done 4 cycles later, S=0x30; S keeps the first result until then.
- rst asserted 2 cycles into an operation -> S, Cout, ovf, busy, done all 0 immediately. After release, A=0x0A, B=0x05, d=1 -> S=0x05, Cout=1, ovf=0.
